pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_if.sv | 36 +++
 rtl/pipe_hazard_ctrl.sv | 75 +++++++
 tb/tb_pipe_hazard_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle: ID/EX hazard inputs toward the controller and the
// stall/flush/bubble controls plus status back to the pipeline.
interface pipe_hazard_ctrl_if #(
   parameter int unsigned REGW = 5,
   parameter int unsigned CNTW = 32
);
   logic [REGW-1:0] p_ID_Rs;
   logic [REGW-1:0] p_ID_Rt;
   logic            p_ID_Uses_Rt;
   logic            p_EX_MemRead;
   logic [REGW-1:0] p_EX_Rd;
   logic            p_EX_Branch_Taken;
   logic            p_ID_MDU_Start;
   logic            p_MDU_Done;

   logic            p_PC_Stall;
   logic            p_IF_ID_Stall;
   logic            p_IF_ID_Flush;
   logic            p_ID_EX_Bubble;
   logic [1:0]      p_Ctrl_State;
   logic [CNTW-1:0] p_Stall_Count;

   modport master (
      output p_ID_Rs, p_ID_Rt, p_ID_Uses_Rt, p_EX_MemRead, p_EX_Rd,
             p_EX_Branch_Taken, p_ID_MDU_Start, p_MDU_Done,
      input  p_PC_Stall, p_IF_ID_Stall, p_IF_ID_Flush, p_ID_EX_Bubble,
             p_Ctrl_State, p_Stall_Count
   );

   modport slave (
      input  p_ID_Rs, p_ID_Rt, p_ID_Uses_Rt, p_EX_MemRead, p_EX_Rd,
             p_EX_Branch_Taken, p_ID_MDU_Start, p_MDU_Done,
      output p_PC_Stall, p_IF_ID_Stall, p_IF_ID_Flush, p_ID_EX_Bubble,
             p_Ctrl_State, p_Stall_Count
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, multi-cycle MDU wait and
// taken-branch flush, with a saturating count of stalled cycles.
module pipe_hazard_ctrl #(
   parameter int unsigned REGW = 5,
   parameter int unsigned CNTW = 32
) (
   input  logic               p_clk,
   input  logic               p_reset_l,
   pipe_hazard_ctrl_if.slave  hz
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      MDU_WAIT = 2'd2,
      FLUSH    = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic            flush_q;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            load_use;
   logic            stall;

   assign load_use = hz.p_EX_MemRead
                   & (hz.p_EX_Rd != REGW'(0))
                   & ((hz.p_EX_Rd == hz.p_ID_Rs)
                      | (hz.p_ID_Uses_Rt & (hz.p_EX_Rd == hz.p_ID_Rt)));

   // Next state: a taken branch wins over everything, in every state.
   always_comb begin
      state_d = state_q;
      if (hz.p_EX_Branch_Taken) begin
         state_d = FLUSH;
      end else begin
         case (state_q)
            RUN: begin
               if (hz.p_ID_MDU_Start) state_d = MDU_WAIT;
               else if (load_use)     state_d = LU_STALL;
            end
            LU_STALL: state_d = RUN;
            MDU_WAIT: if (hz.p_MDU_Done) state_d = RUN;
            FLUSH:    state_d = RUN;
            default:  state_d = RUN;
         endcase
      end
   end

   // Reset gating keeps the stall outputs low while reset is held.
   assign stall = p_reset_l
                & (((state_q == RUN) & load_use & ~hz.p_EX_Branch_Taken)
                   | (state_q == MDU_WAIT));

   assign cnt_d = (stall && (cnt_q != {CNTW{1'b1}})) ? cnt_q + CNTW'(1) : cnt_q;

   always_ff @(posedge p_clk or negedge p_reset_l) begin
      if (!p_reset_l) begin
         state_q <= RUN;
         flush_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         flush_q <= (state_d == FLUSH);
         cnt_q   <= cnt_d;
      end
   end

   assign hz.p_PC_Stall     = stall;
   assign hz.p_IF_ID_Stall  = stall;
   assign hz.p_IF_ID_Flush  = flush_q;
   assign hz.p_ID_EX_Bubble = stall | (state_q == FLUSH);
   assign hz.p_Ctrl_State   = 2'(state_q);
   assign hz.p_Stall_Count  = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, directed corner
// sequences, and randomized traffic against a behavioural model.
module tb_pipe_hazard_ctrl;

   logic clk;
   logic rst_l;

   pipe_hazard_ctrl_if #(.REGW(5), .CNTW(32)) hz ();
   pipe_hazard_ctrl_if #(.REGW(5), .CNTW(3))  hz3 ();

   pipe_hazard_ctrl #(.REGW(5), .CNTW(32)) dut (
      .p_clk     (clk),
      .p_reset_l (rst_l),
      .hz        (hz)
   );

   // Narrow-counter copy sharing the same stimulus, to reach saturation.
   pipe_hazard_ctrl #(.REGW(5), .CNTW(3)) dut3 (
      .p_clk     (clk),
      .p_reset_l (rst_l),
      .hz        (hz3)
   );

   assign hz3.p_ID_Rs           = hz.p_ID_Rs;
   assign hz3.p_ID_Rt           = hz.p_ID_Rt;
   assign hz3.p_ID_Uses_Rt      = hz.p_ID_Uses_Rt;
   assign hz3.p_EX_MemRead      = hz.p_EX_MemRead;
   assign hz3.p_EX_Rd           = hz.p_EX_Rd;
   assign hz3.p_EX_Branch_Taken = hz.p_EX_Branch_Taken;
   assign hz3.p_ID_MDU_Start    = hz.p_ID_MDU_Start;
   assign hz3.p_MDU_Done        = hz.p_MDU_Done;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [4:0] rs, rt;
      logic       ut, mr;
      logic [4:0] rd;
      logic       br, st, dn;
      logic       stall, bub;
      logic [1:0] nxt;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                        input logic mr, input logic [4:0] rd, input logic br,
                        input logic st, input logic dn);
      hz.p_ID_Rs = rs; hz.p_ID_Rt = rt; hz.p_ID_Uses_Rt = ut;
      hz.p_EX_MemRead = mr; hz.p_EX_Rd = rd; hz.p_EX_Branch_Taken = br;
      hz.p_ID_MDU_Start = st; hz.p_MDU_Done = dn;
   endtask

   task automatic idle();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic expect_out(input string tag, input int st, input bit stall,
                             input bit bub, input bit fl, input longint cnt);
      chk({tag, "_state"}, longint'(hz.p_Ctrl_State), longint'(st));
      chk({tag, "_pcstall"}, longint'(hz.p_PC_Stall), longint'(stall));
      chk({tag, "_ifidstall"}, longint'(hz.p_IF_ID_Stall), longint'(stall));
      chk({tag, "_bubble"}, longint'(hz.p_ID_EX_Bubble), longint'(bub));
      chk({tag, "_flush"}, longint'(hz.p_IF_ID_Flush), longint'(fl));
      chk({tag, "_count"}, longint'(hz.p_Stall_Count), cnt);
   endtask

   // Reset asserted and released mid-cycle, away from both clock edges.
   task automatic do_reset();
      @(posedge clk); #2;
      rst_l = 1'b0;
      idle();
      @(posedge clk); #2;
      rst_l = 1'b1;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Behavioural model state for the random phase.
   bit     m_mdu, m_flush, m_lu;
   longint m_cnt, m_cnt3;

   task automatic model_check_and_advance(input int cyc);
      bit lu, exp_stall, exp_bub;
      int exp_state;
      string tag;
      lu = hz.p_EX_MemRead && (hz.p_EX_Rd != 5'd0) &&
           ((hz.p_EX_Rd == hz.p_ID_Rs) || (hz.p_ID_Uses_Rt && (hz.p_EX_Rd == hz.p_ID_Rt)));
      exp_state = m_flush ? 3 : (m_mdu ? 2 : (m_lu ? 1 : 0));
      exp_stall = m_mdu || (!m_flush && !m_mdu && !m_lu && lu && !hz.p_EX_Branch_Taken);
      exp_bub   = exp_stall || m_flush;
      tag = $sformatf("rnd%0d", cyc);
      expect_out(tag, exp_state, exp_stall, exp_bub, m_flush, m_cnt);
      chk({tag, "_count3"}, longint'(hz3.p_Stall_Count), m_cnt3);
      if (exp_stall) begin
         if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
         if (m_cnt3 < 7) m_cnt3++;
      end
      if (hz.p_EX_Branch_Taken) begin
         m_flush = 1; m_mdu = 0; m_lu = 0;
      end else if (m_mdu) begin
         m_mdu = !hz.p_MDU_Done;
      end else if (m_flush || m_lu) begin
         m_flush = 0; m_lu = 0;
      end else if (hz.p_ID_MDU_Start) begin
         m_mdu = 1;
      end else if (lu) begin
         m_lu = 1;
      end
   endtask

   initial begin
      //           rs     rt     ut mr  rd     br st dn stl bub nxt
      vecs[0]  = '{5'd5,  5'd0,  0, 1, 5'd5,  0, 0, 0, 1, 1, 2'd1};
      vecs[1]  = '{5'd0,  5'd0,  0, 1, 5'd0,  0, 0, 0, 0, 0, 2'd0};
      vecs[2]  = '{5'd3,  5'd7,  1, 1, 5'd7,  0, 0, 0, 1, 1, 2'd1};
      vecs[3]  = '{5'd3,  5'd7,  0, 1, 5'd7,  0, 0, 0, 0, 0, 2'd0};
      vecs[4]  = '{5'd5,  5'd0,  0, 0, 5'd5,  0, 0, 0, 0, 0, 2'd0};
      vecs[5]  = '{5'd5,  5'd0,  0, 1, 5'd5,  1, 0, 0, 0, 0, 2'd3};
      vecs[6]  = '{5'd0,  5'd0,  0, 0, 5'd0,  0, 1, 0, 0, 0, 2'd2};
      vecs[7]  = '{5'd0,  5'd0,  0, 0, 5'd0,  0, 0, 1, 0, 0, 2'd0};
      vecs[8]  = '{5'd0,  5'd0,  0, 0, 5'd0,  1, 1, 0, 0, 0, 2'd3};
      vecs[9]  = '{5'd31, 5'd0,  0, 1, 5'd31, 0, 0, 0, 1, 1, 2'd1};
      vecs[10] = '{5'd4,  5'd0,  1, 1, 5'd0,  0, 0, 0, 0, 0, 2'd0};
      vecs[11] = '{5'd9,  5'd9,  1, 1, 5'd8,  0, 0, 0, 0, 0, 2'd0};

      rst_l = 1'b0;
      idle();
      #3;
      expect_out("reset", 0, 0, 0, 0, 0);
      step();
      #1 rst_l = 1'b1;

      // Single-cycle vectors, each from a fresh reset in RUN.
      for (int i = 0; i < 12; i++) begin
         do_reset();
         drive(vecs[i].rs, vecs[i].rt, vecs[i].ut, vecs[i].mr, vecs[i].rd,
               vecs[i].br, vecs[i].st, vecs[i].dn);
         @(negedge clk);
         expect_out($sformatf("vec%0d_now", i), 0, vecs[i].stall, vecs[i].bub, 0, 0);
         step();
         idle();
         #1;
         expect_out($sformatf("vec%0d_next", i), int'(vecs[i].nxt),
                    vecs[i].nxt == 2'd2,
                    (vecs[i].nxt == 2'd2) || (vecs[i].nxt == 2'd3),
                    vecs[i].nxt == 2'd3, longint'(vecs[i].stall));
      end

      // Load-use returns to RUN after one LU_STALL cycle.
      do_reset();
      drive(5'd5, 5'd0, 0, 1, 5'd5, 0, 0, 0);
      step();
      idle();
      step();
      expect_out("lu_back", 0, 0, 0, 0, 1);

      // MDU wait of seven cycles, with a stray start ignored mid-wait.
      do_reset();
      drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0);
      step();
      idle();
      for (int i = 1; i <= 7; i++) begin
         hz.p_ID_MDU_Start = (i == 3);
         hz.p_MDU_Done     = (i == 7);
         @(negedge clk);
         expect_out($sformatf("mdu_w%0d", i), 2, 1, 1, 0, longint'(i - 1));
         step();
         idle();
      end
      #1;
      expect_out("mdu_done", 0, 0, 0, 0, 7);

      // Branch during MDU wait flushes for exactly one cycle.
      do_reset();
      drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0);
      step();
      idle();
      step();
      step();
      hz.p_EX_Branch_Taken = 1'b1;
      @(negedge clk);
      expect_out("mdu_br_cyc", 2, 1, 1, 0, 2);
      step();
      idle();
      #1;
      expect_out("mdu_br_flush", 3, 0, 1, 1, 3);
      step();
      expect_out("mdu_br_after", 0, 0, 0, 0, 3);

      // Back-to-back branches hold FLUSH; MDU done outside wait is ignored.
      do_reset();
      drive(5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0);
      step();
      hz.p_MDU_Done = 1'b1;
      #1;
      expect_out("flush_a", 3, 0, 1, 1, 0);
      step();
      idle();
      #1;
      expect_out("flush_b", 3, 0, 1, 1, 0);
      step();
      expect_out("flush_end", 0, 0, 0, 0, 0);

      // Asynchronous reset mid-MDU-wait with a live load-use on the inputs.
      do_reset();
      drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0);
      step();
      idle();
      step();
      step();
      step();
      expect_out("pre_rst", 2, 1, 1, 0, 3);
      #2;
      drive(5'd5, 5'd0, 0, 1, 5'd5, 0, 0, 0);
      rst_l = 1'b0;
      #1;
      expect_out("async_rst", 0, 0, 0, 0, 0);
      step();
      idle();
      #1 rst_l = 1'b1;
      step();
      expect_out("post_rst", 0, 0, 0, 0, 0);

      // Asynchronous reset mid-FLUSH clears the flush flop at once.
      hz.p_EX_Branch_Taken = 1'b1;
      step();
      idle();
      #1;
      chk("flush_pre_rst", longint'(hz.p_IF_ID_Flush), 1);
      rst_l = 1'b0;
      #1;
      chk("flush_async_rst", longint'(hz.p_IF_ID_Flush), 0);
      chk("flush_async_state", longint'(hz.p_Ctrl_State), 0);
      step();
      #1 rst_l = 1'b1;

      // Randomized traffic against the behavioural model.
      do_reset();
      m_mdu = 0; m_flush = 0; m_lu = 0; m_cnt = 0; m_cnt3 = 0;
      for (int c = 0; c < 600; c++) begin
         @(posedge clk); #1;
         drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
               5'($urandom_range(0, 3)), 1'($urandom_range(0, 15) == 0),
               1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) == 0));
         @(negedge clk);
         model_check_and_advance(c);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
